// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM arbiter between scanout fetch and CPU port.
// Scanout reads have absolute priority. CPU accesses use the cycles where
// scan_req is low. Define VRAM_ARB_STATS_EN to add the cpu_wait_max port
// (longest consecutive WAIT time of any CPU transaction, saturating).
module vram_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 12
) (
    input  logic                  clk_25m,
    input  logic                  rst_n,
    input  logic                  scan_req,
    input  logic [ADDR_WIDTH-1:0] scan_addr,
    output logic [DATA_WIDTH-1:0] scan_rdata,
    output logic                  scan_rvalid,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
`ifdef VRAM_ARB_STATS_EN
    output logic [15:0]           cpu_wait_max,
`endif
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_ISSUE = 3'd2,
        S_RDATA = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic                    cpu_ack_q, cpu_ack_d;
    logic [DATA_WIDTH-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic                    mem_en_q, mem_en_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [1:0]              scan_v_q;
    logic                    scan_rvalid_q;
    logic [DATA_WIDTH-1:0]   scan_rdata_q;

    // Owner selection, CPU FSM next state and next values of registered outputs
    always_comb begin
        state_d     = state_q;
        cpu_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        if (scan_req) begin
            mem_en_d   = 1'b1;
            mem_addr_d = scan_addr;
        end

        case (state_q)
            S_IDLE: begin
                if (cpu_req) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!cpu_req) begin
                    state_d = S_IDLE;
                end else if (!scan_req) begin
                    mem_en_d    = 1'b1;
                    mem_we_d    = cpu_we;
                    mem_addr_d  = cpu_addr;
                    mem_wdata_d = cpu_wdata;
                    // Write ack lands in the same cycle as the RAM write
                    cpu_ack_d   = cpu_we;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // mem_we_q is high in ISSUE exactly when the issued op is a write
                state_d = mem_we_q ? S_DONE : S_RDATA;
            end
            S_RDATA: begin
                cpu_ack_d   = 1'b1;
                cpu_rdata_d = mem_rdata;
                state_d     = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state and CPU/RAM-side output registers
    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Scanout read tracking: request -> RAM cycle -> data cycle -> registered output
    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            scan_v_q      <= 2'b00;
            scan_rvalid_q <= 1'b0;
            scan_rdata_q  <= '0;
        end else begin
            scan_v_q      <= {scan_v_q[0], scan_req};
            scan_rvalid_q <= scan_v_q[1];
            if (scan_v_q[1]) scan_rdata_q <= mem_rdata;
        end
    end

    assign scan_rdata  = scan_rdata_q;
    assign scan_rvalid = scan_rvalid_q;
    assign cpu_ack     = cpu_ack_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;

`ifdef VRAM_ARB_STATS_EN
    localparam int unsigned STAT_W = 16;

    logic [STAT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [STAT_W-1:0] wait_max_q, wait_max_d;

    // Saturating run length of the current WAIT stay and its running maximum
    always_comb begin
        wait_cnt_d = '0;
        wait_max_d = wait_max_q;
        if (state_q == S_WAIT) begin
            wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + STAT_W'(1);
            if (wait_cnt_d > wait_max_q) wait_max_d = wait_cnt_d;
        end
    end

    // Statistics registers
    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            wait_max_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            wait_max_q <= wait_max_d;
        end
    end

    assign cpu_wait_max = wait_max_q;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter with a behavioural block RAM.
module tb_vram_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 12;

    logic          clk_25m = 1'b0;
    logic          rst_n;
    logic          scan_req;
    logic [AW-1:0] scan_addr;
    logic [DW-1:0] scan_rdata;
    logic          scan_rvalid;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
`ifdef VRAM_ARB_STATS_EN
    logic [15:0]   cpu_wait_max;
`endif

    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic          any_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_25m = ~clk_25m;

    vram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_25m     (clk_25m),
        .rst_n       (rst_n),
        .scan_req    (scan_req),
        .scan_addr   (scan_addr),
        .scan_rdata  (scan_rdata),
        .scan_rvalid (scan_rvalid),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ack     (cpu_ack),
        .cpu_rdata   (cpu_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
`ifdef VRAM_ARB_STATS_EN
        .cpu_wait_max(cpu_wait_max),
`endif
        .mem_rdata   (mem_rdata)
    );

    // Synchronous RAM: data for an enabled cycle appears in the following cycle
    always @(posedge clk_25m) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    assign any_out = |{scan_rdata, scan_rvalid, cpu_ack, cpu_rdata,
                       mem_en, mem_we, mem_addr, mem_wdata};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One CPU transaction; lat counts negedges after the one that raised cpu_req
    task automatic cpu_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int budget, output int lat, output logic [DW-1:0] rd,
                           output int n_wr, output logic [AW-1:0] wa);
        lat = -1; rd = '0; n_wr = 0; wa = '0;
        @(negedge clk_25m);
        cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk_25m);
            if (mem_en && mem_we) begin n_wr++; wa = mem_addr; end
            if (cpu_ack) begin lat = i; rd = cpu_rdata; break; end
        end
        cpu_req = 1'b0;
    endtask

    task automatic idle_watch(input int n, output int acks, output int wrs);
        acks = 0; wrs = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_25m);
            if (cpu_ack) acks++;
            if (mem_en && mem_we) wrs++;
        end
    endtask

    int            lat, n_wr, acks, wrs, second;
    int            rv_cnt, first_rv, data_err, we_seen, en_cnt;
    logic [DW-1:0] rd;
    logic [AW-1:0] wa;

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = DW'(i);
        rst_n = 1'b0; scan_req = 1'b0; scan_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(negedge clk_25m);
        check("reset_outputs", 32'(any_out), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_25m);

        // Scan only: 640 back-to-back reads, RAM returns data = address
        rv_cnt = 0; first_rv = -1; data_err = 0; we_seen = 0; en_cnt = 0;
        for (int c = 0; c < 646; c++) begin
            @(negedge clk_25m);
            if (scan_rvalid) begin
                if (first_rv < 0) first_rv = c;
                if (scan_rdata != DW'(c - 3)) data_err++;
                rv_cnt++;
            end
            if (mem_we) we_seen++;
            if (mem_en) en_cnt++;
            scan_req  = (c < 640);
            scan_addr = AW'(c);
        end
        scan_req = 1'b0;
        check("scan_rvalid_count", 32'(rv_cnt), 32'd640);
        check("scan_first_rvalid", 32'(first_rv), 32'd3);
        check("scan_data_errors", 32'(data_err), 32'd0);
        check("scan_mem_we", 32'(we_seen), 32'd0);
        check("scan_mem_en_count", 32'(en_cnt), 32'd640);

        // CPU write while idle, then read back
        cpu_txn(1'b1, 16'h0010, 12'hF0F, 20, lat, rd, n_wr, wa);
        check("wr_ack_latency", 32'(lat), 32'd2);
        check("wr_access_count", 32'(n_wr), 32'd1);
        check("wr_addr", 32'(wa), 32'h0010);
        idle_watch(6, acks, wrs);
        check("wr_extra_ack", 32'(acks), 32'd0);
        cpu_txn(1'b0, 16'h0010, 12'h000, 20, lat, rd, n_wr, wa);
        check("rd_ack_latency", 32'(lat), 32'd4);
        check("rd_data", 32'(rd), 32'hF0F);
        check("rd_no_write", 32'(n_wr), 32'd0);
        repeat (3) @(negedge clk_25m);

        // Contention: scanout busy for 100 cycles while a CPU write waits
        rv_cnt = 0; data_err = 0;
        fork
            begin
                cpu_txn(1'b1, 16'h0020, 12'h5A5, 200, lat, rd, n_wr, wa);
            end
            begin
                for (int k = 0; k < 103; k++) begin
                    @(negedge clk_25m);
                    if (k >= 3) begin
                        if (scan_rvalid) rv_cnt++;
                        if (!scan_rvalid || scan_rdata != DW'(1000 + k - 3)) data_err++;
                    end
                    scan_req  = (k < 100);
                    scan_addr = AW'(1000 + k);
                end
                scan_req = 1'b0;
            end
        join
        check("cont_ack_latency", 32'(lat), 32'd101);
        check("cont_access_count", 32'(n_wr), 32'd1);
        check("cont_addr", 32'(wa), 32'h0020);
        check("cont_scan_rvalid", 32'(rv_cnt), 32'd100);
        check("cont_scan_errors", 32'(data_err), 32'd0);
`ifdef VRAM_ARB_STATS_EN
        check("wait_max_ge_100", 32'(cpu_wait_max >= 16'd100), 32'd1);
`endif
        repeat (3) @(negedge clk_25m);

        // Held request: one dead cycle, then a second transaction
        acks = 0; wrs = 0; second = -1;
        @(negedge clk_25m);
        cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 12'h123; cpu_req = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk_25m);
            if (cpu_ack) begin acks++; if (acks == 2) second = i; end
            if (mem_en && mem_we) wrs++;
        end
        cpu_req = 1'b0;
        check("held_ack_count", 32'(acks), 32'd2);
        check("held_access_count", 32'(wrs), 32'd2);
        check("held_second_ack", 32'(second), 32'd6);
        repeat (4) @(negedge clk_25m);

        // Reset asserted while the read is in RDATA
        @(negedge clk_25m);
        cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_req = 1'b1;
        repeat (3) @(negedge clk_25m);
        check("pre_reset_mem_addr", 32'(mem_addr), 32'h0010);
        #1 rst_n = 1'b0;
        #1 check("async_reset_outputs", 32'(any_out), 32'd0);
        cpu_req = 1'b0;
        repeat (2) @(negedge clk_25m);
        rst_n = 1'b1;
        idle_watch(6, acks, wrs);
        check("post_reset_no_ack", 32'(acks), 32'd0);
        cpu_txn(1'b1, 16'h0060, 12'h777, 20, lat, rd, n_wr, wa);
        check("post_reset_wr_latency", 32'(lat), 32'd2);
        repeat (3) @(negedge clk_25m);

        // Abort: cpu_req dropped while waiting behind scanout
        acks = 0; wrs = 0;
        fork
            begin
                @(negedge clk_25m);
                cpu_we = 1'b1; cpu_addr = 16'h0050; cpu_wdata = 12'hABC; cpu_req = 1'b1;
                for (int i = 1; i <= 35; i++) begin
                    @(negedge clk_25m);
                    if (cpu_ack) acks++;
                    if (mem_en && mem_we) wrs++;
                    if (i == 5) cpu_req = 1'b0;
                end
            end
            begin
                for (int k = 0; k < 31; k++) begin
                    @(negedge clk_25m);
                    scan_req  = (k < 30);
                    scan_addr = AW'(2000 + k);
                end
                scan_req = 1'b0;
            end
        join
        check("abort_no_ack", 32'(acks), 32'd0);
        check("abort_no_access", 32'(wrs), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port video RAM arbiter shared between the scanout pixel fetcher and the CPU-side access port, clocked by the pixel clock. Scanout reads have absolute priority so the VGA raster never stalls. CPU reads and writes are served in cycles with no scanout request, which in practice means the horizontal and vertical blanking intervals. The block sits between the VGA timing/pixel-fetch logic and the block RAM holding the framebuffer.

## Interface
- ADDR_WIDTH, 16, VRAM word address width
- DATA_WIDTH, 12, VRAM word width (RGB444)
- clk_25m  in  1  pixel clock; all logic on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- scan_req  in  1  scanout read request, sampled every cycle, no handshake
- scan_addr  in  ADDR_WIDTH  scanout read address, valid with scan_req
- scan_rdata  out  DATA_WIDTH  scanout read data
- scan_rvalid  out  1  scan_rdata valid this cycle
- cpu_req  in  1  CPU request; held high until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
- cpu_addr  in  ADDR_WIDTH  CPU address; stable while cpu_req is high
- cpu_wdata  in  DATA_WIDTH  CPU write data; stable while cpu_req is high
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_WIDTH  CPU read data, valid while cpu_ack is high (read only)
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_wdata  out  DATA_WIDTH  RAM write data
- mem_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after mem_en is sampled high

## Operation
- Owner selection per cycle: if scan_req = 1, scanout owns the next RAM cycle. Otherwise a CPU transaction in WAIT owns it.
- All mem_* outputs are registered. mem_en = 0 in any cycle with no owner. mem_we = 1 only for a CPU write.
- CPU FSM states:
  - IDLE: if cpu_req, go to WAIT.
  - WAIT: if cpu_req drops, go to IDLE with no access. Else if scan_req = 0, latch the operation into mem_* and go to ISSUE.
  - ISSUE: for a write, pulse cpu_ack and go to DONE. For a read, go to RDATA.
  - RDATA: capture mem_rdata into cpu_rdata, pulse cpu_ack, go to DONE.
  - DONE: go to IDLE. This gives one mandatory dead cycle, so a held cpu_req is not re-accepted.
- Once in ISSUE, the transaction always completes, even if cpu_req is dropped.
- Scanout pipeline: a 2-stage valid shift register tracks outstanding scanout reads. scan_rdata is registered from mem_rdata when the tracked read returns.
- No starvation guard. If scan_req is held continuously, the CPU waits. The raster's blanking (160 cycles/line) bounds the wait.
- Reset (async assert, any state): FSM goes to IDLE. All outputs and pipeline registers are 0. An in-flight CPU transaction is dropped with no cpu_ack. In-flight scanout reads are discarded.

## Timing
- Scanout: scan_req sampled high in cycle N gives mem_en = 1 in cycle N+1, and scan_rvalid = 1 with data in cycle N+3. Fixed latency 3, throughput 1 read/cycle.
- CPU write granted (WAIT, scan_req = 0) in cycle N: mem_en/mem_we = 1 in N+1, cpu_ack in N+1.
- CPU read granted in cycle N: mem_en in N+1, cpu_ack and cpu_rdata in N+3.
- Best case from cpu_req rising at cycle N (no scan traffic): write ack in N+2, read ack in N+4.
- Simultaneous scan_req and CPU in WAIT: scanout wins; the CPU stays in WAIT.
- Reset values: scan_rdata = 0, scan_rvalid = 0, cpu_ack = 0, cpu_rdata = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.

## Configuration
- VRAM_ARB_STATS_EN defined:
  - Adds output port cpu_wait_max, 16 bits, register.
  - It holds the largest number of consecutive cycles any CPU transaction spent in WAIT.
  - Saturates at 16'hFFFF and resets to 0.
- Not defined: the port and its counter logic are absent. Arbitration behaviour is identical either way.

## Test plan
- Scan only: scan_req high for 640 cycles, addresses 0..639, RAM model returns data = address. Expect scan_rvalid high for 640 cycles starting 3 cycles after the first request, data 0..639 in order, mem_we never 1.
- CPU write while idle: addr 0x0010, data 0xF0F. Expect one cycle with mem_en = 1, mem_we = 1, addr 0x0010, then cpu_ack exactly once. A later read of 0x0010 returns 0xF0F with cpu_ack 4 cycles after cpu_req rises.
- Contention: cpu_req (write) raised mid-line while scan_req is high for 100 more cycles. Expect no CPU access during those cycles, the write issued on the first cycle scan_req = 0, and scanout data intact. With VRAM_ARB_STATS_EN, expect cpu_wait_max ≥ 100.
- Held request: cpu_req held high after ack. Expect one DONE dead cycle, then a second transaction starts (ack count 2 over the window, no double access in one transaction).
- Reset mid-transaction: rst_n low during RDATA. Expect all outputs 0 immediately (asynchronous), no cpu_ack, and the FSM in IDLE after release.
- Abort: cpu_req dropped while in WAIT (scan busy). Expect no mem_en for the CPU and no cpu_ack.
